// File: rtl/bin_to_bcd6.sv
// bin_to_bcd6: iterative double-dabble converter, 20-bit binary to six BCD
// digits, one bit per clock. The digits are registered and change only when a
// conversion completes, so the display driver never sees partial results.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; output digits hold the last result
// SHIFT | one add-3/shift step per clock, 20 steps in total
// DONE  | load the output digits and ovf, pulse done, return to IDLE

module bin_to_bcd6 #(
  parameter bit SAT = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  led1,
  output logic [3:0]  led2,
  output logic [3:0]  led3,
  output logic [3:0]  led4,
  output logic [3:0]  led5,
  output logic [3:0]  led6
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] shreg_q, shreg_d;
  logic [23:0] scratch_q, scratch_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_next_q, ovf_next_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [23:0] digits_q, digits_d;
  logic [23:0] adj;

  // Add 3 to every scratch nibble that is 5 or more, ahead of the shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 6; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d    = bin;
          scratch_d  = 24'd0;
          cnt_d      = 5'd0;
          ovf_next_d = (bin > 20'd999999);
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The carry out of the top nibble is dropped: the 7th digit is
        // truncated, which leaves the lower six digits as bin mod 10^6.
        scratch_d = {adj[22:0], shreg_q[19]};
        shreg_d   = {shreg_q[18:0], 1'b0};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd19) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        digits_d = (ovf_next_q && SAT) ? 24'h999999 : scratch_q;
        ovf_d    = ovf_next_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= 20'd0;
      scratch_q  <= 24'd0;
      cnt_q      <= 5'd0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= 24'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign led1 = digits_q[23:20];
  assign led2 = digits_q[19:16];
  assign led3 = digits_q[15:12];
  assign led4 = digits_q[11:8];
  assign led5 = digits_q[7:4];
  assign led6 = digits_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd6.sv
// Directed bench for bin_to_bcd6: one saturating and one modulo instance
// share the same stimulus; expected digits are hand-computed BCD constants.

module tb_bin_to_bcd6;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [19:0] bin = 20'd0;

  logic       busy_s, done_s, ovf_s;
  logic [3:0] l1_s, l2_s, l3_s, l4_s, l5_s, l6_s;
  logic       busy_m, done_m, ovf_m;
  logic [3:0] l1_m, l2_m, l3_m, l4_m, l5_m, l6_m;
  logic [23:0] led_s, led_m;

  int n_checks = 0;
  int n_fail   = 0;

  assign led_s = {l1_s, l2_s, l3_s, l4_s, l5_s, l6_s};
  assign led_m = {l1_m, l2_m, l3_m, l4_m, l5_m, l6_m};

  always #5 CLK = ~CLK;

  bin_to_bcd6 #(.SAT(1'b1)) dut_sat (
    .CLK(CLK), .reset(reset), .start(start), .bin(bin),
    .busy(busy_s), .done(done_s), .ovf(ovf_s),
    .led1(l1_s), .led2(l2_s), .led3(l3_s), .led4(l4_s), .led5(l5_s), .led6(l6_s)
  );

  bin_to_bcd6 #(.SAT(1'b0)) dut_mod (
    .CLK(CLK), .reset(reset), .start(start), .bin(bin),
    .busy(busy_m), .done(done_m), .ovf(ovf_m),
    .led1(l1_m), .led2(l2_m), .led3(l3_m), .led4(l4_m), .led5(l5_m), .led6(l6_m)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present bin with start for one accepting edge; returns just after E0.
  task automatic do_start(input logic [19:0] v);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edge count (after E0) at which done is first seen high, or -1 on timeout.
  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_s) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] l0;
    reset = 1'b0;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (led_s !== 24'h000000) begin n_fail++; $display("FAIL reset_digits: got %h want 000000", led_s); end
    n_checks++;
    if ({busy_s, done_s, ovf_s} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/done/ovf=%b want 000", {busy_s, done_s, ovf_s}); end
    n_checks++;
    if ({led_m, busy_m, done_m, ovf_m} !== 27'd0) begin n_fail++; $display("FAIL reset_mod: got %h/%b want 0", led_m, {busy_m, done_m, ovf_m}); end
    l0 = led_s;
    for (int c = 0; c < 50; c++) begin
      tick();
      n_checks++;
      if ({led_s, busy_s, done_s, ovf_s} !== {l0, 3'b000}) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: got %h/%b want %h/000", c, led_s, {busy_s, done_s, ovf_s}, l0);
      end
    end
  endtask

  task automatic test_nominal();
    int k;
    do_start(20'd123456);
    n_checks++;
    if (busy_s !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b want 1", busy_s); end
    wait_done(k);
    n_checks++;
    if (k != 21) begin n_fail++; $display("FAIL nominal_latency: got %0d want 21", k); end
    n_checks++;
    if (led_s !== 24'h123456 || ovf_s !== 1'b0) begin n_fail++; $display("FAIL nominal_123456: got %h ovf=%b want 123456 ovf=0", led_s, ovf_s); end
    n_checks++;
    if (busy_s !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy_s); end
    tick();
    n_checks++;
    if (done_s !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", done_s); end

    do_start(20'd0);
    wait_done(k);
    n_checks++;
    if (k != 21 || led_s !== 24'h000000) begin n_fail++; $display("FAIL nominal_zero: got k=%0d %h want 21 000000", k, led_s); end

    do_start(20'd999999);
    wait_done(k);
    n_checks++;
    if (led_s !== 24'h999999 || ovf_s !== 1'b0) begin n_fail++; $display("FAIL nominal_999999: got %h ovf=%b want 999999 ovf=0", led_s, ovf_s); end
    n_checks++;
    if (led_m !== 24'h999999 || ovf_m !== 1'b0) begin n_fail++; $display("FAIL mod_999999: got %h ovf=%b want 999999 ovf=0", led_m, ovf_m); end
  endtask

  task automatic test_overflow();
    int k;
    do_start(20'd1000000);
    wait_done(k);
    n_checks++;
    if (led_s !== 24'h999999 || ovf_s !== 1'b1) begin n_fail++; $display("FAIL sat_1000000: got %h ovf=%b want 999999 ovf=1", led_s, ovf_s); end
    n_checks++;
    if (led_m !== 24'h000000 || ovf_m !== 1'b1 || done_m !== 1'b1) begin n_fail++; $display("FAIL mod_1000000: got %h ovf=%b done=%b want 000000 1 1", led_m, ovf_m, done_m); end

    do_start(20'd1048575);
    wait_done(k);
    n_checks++;
    if (led_m !== 24'h048575 || ovf_m !== 1'b1) begin n_fail++; $display("FAIL mod_1048575: got %h ovf=%b want 048575 ovf=1", led_m, ovf_m); end
    n_checks++;
    if (led_s !== 24'h999999 || ovf_s !== 1'b1) begin n_fail++; $display("FAIL sat_1048575: got %h ovf=%b want 999999 ovf=1", led_s, ovf_s); end
  endtask

  task automatic test_start_while_busy();
    logic [23:0] prev;
    int ndone, first_k, hold_bad;
    prev     = led_m;
    ndone    = 0;
    first_k  = -1;
    hold_bad = 0;
    do_start(20'd42);
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bin   = 20'd777;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done_m) begin
        ndone++;
        if (first_k < 0) first_k = k;
      end
      if (k < 21 && led_m !== prev) hold_bad++;
    end
    n_checks++;
    if (ndone != 1 || first_k != 21) begin n_fail++; $display("FAIL busy_single_done: got %0d dones first at %0d want 1 at 21", ndone, first_k); end
    n_checks++;
    if (led_m !== 24'h000042 || ovf_m !== 1'b0) begin n_fail++; $display("FAIL busy_digits: got %h ovf=%b want 000042 ovf=0", led_m, ovf_m); end
    n_checks++;
    if (hold_bad != 0) begin n_fail++; $display("FAIL busy_hold: got %0d changed cycles want 0", hold_bad); end
  endtask

  task automatic test_back_to_back();
    int k;
    do_start(20'd250);
    wait_done(k);
    n_checks++;
    if (k != 21 || led_s !== 24'h000250) begin n_fail++; $display("FAIL b2b_first: got k=%0d %h want 21 000250", k, led_s); end
    // start presented while done is high
    do_start(20'd65535);
    n_checks++;
    if (busy_s !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", busy_s); end
    wait_done(k);
    n_checks++;
    if (k != 21 || led_s !== 24'h065535) begin n_fail++; $display("FAIL b2b_second: got k=%0d %h want 21 065535", k, led_s); end
  endtask

  task automatic test_reset_mid();
    int k, ndone;
    do_start(20'd314159);
    repeat (9) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({led_s, busy_s, done_s, ovf_s} !== 27'd0) begin n_fail++; $display("FAIL midreset_state: got %h/%b want 000000/000", led_s, {busy_s, done_s, ovf_s}); end
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_s || busy_s) ndone++;
    end
    n_checks++;
    if (ndone != 0 || led_s !== 24'h000000) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles %h want 0 000000", ndone, led_s); end
    do_start(20'd314159);
    wait_done(k);
    n_checks++;
    if (k != 21 || led_s !== 24'h314159) begin n_fail++; $display("FAIL midreset_restart: got k=%0d %h want 21 314159", k, led_s); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
